// File: rtl/instr_fetch_unit.sv
// -----------------------------------------------------------------------------
// instr_fetch_unit
//
// Fetch stage that sits directly after the combinational instruction memory.
// It owns the PC and drives it to imem. Each returned word is captured,
// together with its PC, into a small prefetch FIFO. The FIFO head is offered
// to decode over a valid/ready handshake. The block also handles the boot
// hold-off, branch/jump redirects (which flush the FIFO) and halting on
// ebreak.
//
// Ports:
//   clk            system clock, rising edge
//   rst_n          asynchronous active-low reset
//   boot_done      register-file preload complete; fetch may start
//   imem_addr      byte address to imem (always equal to the PC register)
//   imem_instr     combinational instruction word for imem_addr
//   redirect_valid one-cycle request to change the PC (flushes the FIFO)
//   redirect_pc    redirect target byte address (bits [1:0] ignored)
//   out_valid      FIFO head valid
//   out_ready      decode accepts the head this cycle
//   out_instr      head instruction
//   out_pc         head PC
//   halted         ebreak has been consumed and nothing is left to hand out
//
// Optional feature (macro FETCH_PERF_CNT_EN):
//   fetch_count    number of words popped by decode (wraps)
//   stall_count    number of cycles with out_valid && !out_ready (wraps)
// -----------------------------------------------------------------------------
module instr_fetch_unit #(
  parameter logic [31:0] RESET_PC   = 32'h0000_0000,
  parameter int          FIFO_DEPTH = 2,
  parameter logic [31:0] HALT_INSTR = 32'h0010_0073
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        boot_done,
  output logic [31:0] imem_addr,
  input  logic [31:0] imem_instr,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_instr,
  output logic [31:0] out_pc,
  output logic        halted
`ifdef FETCH_PERF_CNT_EN
  ,
  output logic [31:0] fetch_count,
  output logic [31:0] stall_count
`endif
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(FIFO_DEPTH);

  typedef enum logic [1:0] {
    ST_BOOT,
    ST_FETCH,
    ST_HALT
  } state_t;

  state_t             state_reg,  state_next;
  logic [31:0]        pc_reg,     pc_next;
  logic [CNT_W-1:0]   count_reg,  count_next;
  logic [PTR_W-1:0]   rd_ptr_reg, rd_ptr_next;
  logic [PTR_W-1:0]   wr_ptr_reg, wr_ptr_next;

  logic [31:0] entry_pc_reg    [FIFO_DEPTH];
  logic [31:0] entry_instr_reg [FIFO_DEPTH];

  logic do_pop;
  logic do_push;

  assign imem_addr = pc_reg;
  assign out_valid = (count_reg != '0);
  assign out_instr = entry_instr_reg[rd_ptr_reg];
  assign out_pc    = entry_pc_reg[rd_ptr_reg];
  assign halted    = (state_reg == ST_HALT) && (count_reg == '0);

  // A redirect discards any same-cycle pop or push.
  assign do_pop  = out_valid && out_ready && !redirect_valid;
  // A full FIFO can still accept a word when the head leaves on the same edge.
  assign do_push = (state_reg == ST_FETCH) && !redirect_valid &&
                   ((count_reg != DEPTH_C) || (out_valid && out_ready));

  always_comb begin
    state_next  = state_reg;
    pc_next     = pc_reg;
    count_next  = count_reg;
    rd_ptr_next = rd_ptr_reg;
    wr_ptr_next = wr_ptr_reg;

    if (redirect_valid) begin
      pc_next     = redirect_pc & 32'hFFFF_FFFC;
      count_next  = '0;
      rd_ptr_next = '0;
      wr_ptr_next = '0;
      // A redirect during boot only moves the PC; fetch still waits for boot_done.
      state_next  = (state_reg == ST_BOOT) ? ST_BOOT : ST_FETCH;
    end else begin
      if ((state_reg == ST_BOOT) && boot_done) begin
        state_next = ST_FETCH;
      end
      if (do_push) begin
        pc_next     = pc_reg + 32'd4;
        wr_ptr_next = wr_ptr_reg + PTR_W'(1);
        // The ebreak itself is still handed to decode.
        if (imem_instr == HALT_INSTR) begin
          state_next = ST_HALT;
        end
      end
      if (do_pop) begin
        rd_ptr_next = rd_ptr_reg + PTR_W'(1);
      end
      case ({do_push, do_pop})
        2'b10:   count_next = count_reg + CNT_W'(1);
        2'b01:   count_next = count_reg - CNT_W'(1);
        default: count_next = count_reg;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg  <= ST_BOOT;
      pc_reg     <= RESET_PC;
      count_reg  <= '0;
      rd_ptr_reg <= '0;
      wr_ptr_reg <= '0;
    end else begin
      state_reg  <= state_next;
      pc_reg     <= pc_next;
      count_reg  <= count_next;
      rd_ptr_reg <= rd_ptr_next;
      wr_ptr_reg <= wr_ptr_next;
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < FIFO_DEPTH; gi++) begin : g_entry
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          entry_pc_reg[gi]    <= '0;
          entry_instr_reg[gi] <= '0;
        end else if (do_push && (wr_ptr_reg == PTR_W'(gi))) begin
          entry_pc_reg[gi]    <= pc_reg;
          entry_instr_reg[gi] <= imem_instr;
        end
      end
    end
  endgenerate

`ifdef FETCH_PERF_CNT_EN
  // Counters survive redirects; only reset clears them.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fetch_count <= '0;
      stall_count <= '0;
    end else begin
      if (do_pop) begin
        fetch_count <= fetch_count + 32'd1;
      end
      if (out_valid && !out_ready) begin
        stall_count <= stall_count + 32'd1;
      end
    end
  end
`endif

endmodule
